// File: rtl/us_period_meter.sv
// Measures period and high time of an asynchronous pulse train in whole microseconds and publishes them as a registered snapshot.
// A rise sampled on clk edge k gives valid in cycle k+SYNC_STAGES+2; there is no backpressure, so the consumer must take each one-cycle strobe.
module us_period_meter #(
    parameter int CLK_PER_US  = 40,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_us,
    output logic [CNT_W-1:0] high_us,
    output logic             sat,
    output logic             valid,
    output logic             busy
);

    localparam int               PSC_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_PER_US - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_sync;

    state_t                 state_q, state_d;
    logic [PSC_W-1:0]       psc_q, psc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
    logic                   hi_sat_q, hi_sat_d;

    logic                   pub_q, pub_d;
    logic [CNT_W-1:0]       pub_per_q, pub_per_d;
    logic [CNT_W-1:0]       pub_hi_q, pub_hi_d;
    logic                   pub_sat_q, pub_sat_d;

    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   sat_q, sat_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;

    logic                   psc_wrap;
    logic [PSC_W-1:0]       psc_nxt;
    logic [CNT_W-1:0]       cnt_inc;

    // Edge pulses are registered so rise and fall see the same latency; N is unaffected.
    always_comb begin
        s_sync  = sync_q[SYNC_STAGES-1];
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_dly_d = s_sync;
        rise_d  = s_sync & ~s_dly_q;
        fall_d  = ~s_sync & s_dly_q;
    end

    // cnt_inc already includes a wrap happening this cycle, so a result equals floor(N/CLK_PER_US).
    always_comb begin
        psc_wrap = (psc_q == PSC_MAX);
        psc_nxt  = psc_wrap ? '0 : psc_q + PSC_W'(1);
        cnt_inc  = (psc_wrap && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        psc_d     = psc_nxt;
        cnt_d     = cnt_inc;
        hi_lat_d  = hi_lat_q;
        hi_sat_d  = hi_sat_q;
        pub_d     = 1'b0;
        pub_per_d = pub_per_q;
        pub_hi_d  = pub_hi_q;
        pub_sat_d = pub_sat_q;

        if (!meas_en) begin
            state_d = ST_IDLE;
            psc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    psc_d   = '0;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    psc_d = '0;
                    cnt_d = '0;
                    if (rise_q) begin
                        state_d = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (fall_q) begin
                        state_d  = ST_LOW;
                        hi_lat_d = cnt_inc;
                        hi_sat_d = (cnt_inc == CNT_MAX);
                    end else if (rise_q) begin
                        // Missed fall: the whole period counts as high time.
                        pub_d     = 1'b1;
                        pub_per_d = cnt_inc;
                        pub_hi_d  = cnt_inc;
                        pub_sat_d = (cnt_inc == CNT_MAX);
                        psc_d     = '0;
                        cnt_d     = '0;
                    end
                end
                ST_LOW: begin
                    if (rise_q) begin
                        state_d   = ST_HIGH;
                        pub_d     = 1'b1;
                        pub_per_d = cnt_inc;
                        pub_hi_d  = hi_lat_q;
                        pub_sat_d = (cnt_inc == CNT_MAX) | hi_sat_q;
                        psc_d     = '0;
                        cnt_d     = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Publish stage; a disable in flight suppresses the strobe and keeps old results.
    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        sat_d    = sat_q;
        valid_d  = pub_q & meas_en;
        busy_d   = (state_d == ST_HIGH) | (state_d == ST_LOW);
        if (pub_q && meas_en) begin
            period_d = pub_per_q;
            high_d   = pub_hi_q;
            sat_d    = pub_sat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            s_dly_q   <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            state_q   <= ST_IDLE;
            psc_q     <= '0;
            cnt_q     <= '0;
            hi_lat_q  <= '0;
            hi_sat_q  <= 1'b0;
            pub_q     <= 1'b0;
            pub_per_q <= '0;
            pub_hi_q  <= '0;
            pub_sat_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_dly_q   <= s_dly_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            hi_lat_q  <= hi_lat_d;
            hi_sat_q  <= hi_sat_d;
            pub_q     <= pub_d;
            pub_per_q <= pub_per_d;
            pub_hi_q  <= pub_hi_d;
            pub_sat_q <= pub_sat_d;
            period_q  <= period_d;
            high_q    <= high_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign period_us = period_q;
    assign high_us   = high_q;
    assign sat       = sat_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_us_period_meter.sv
// Scoreboard bench for us_period_meter: pulse trains in, expected microsecond results queued per rise, monitor checks each valid.
`timescale 1ns/1ps
module tb_us_period_meter;

    localparam int CPU  = 40;
    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int LAT  = SS + 3;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sig_in;
    logic          meas_en;
    logic [CW-1:0] period_us;
    logic [CW-1:0] high_us;
    logic          sat;
    logic          valid;
    logic          busy;

    us_period_meter #(
        .CLK_PER_US (CPU),
        .CNT_W      (CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .meas_en  (meas_en),
        .period_us(period_us),
        .high_us  (high_us),
        .sat      (sat),
        .valid    (valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     per;
        int     hi;
        bit     sat;
        longint rcyc;
    } exp_t;

    exp_t   q[$];
    exp_t   pend;
    exp_t   mon_e;
    bit     pend_vld = 1'b0;
    bit     prev_v   = 1'b0;
    int     n_cmp    = 0;
    int     n_bad    = 0;
    int     n_push   = 0;
    int     n_valid  = 0;
    int     last_per = 0;
    int     last_hi  = 0;
    longint cyc      = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: whole microseconds from clock counts, clipped to the counter range.
    function automatic exp_t model(input int h, input int p);
        exp_t e;
        e.per  = (p / CPU > MAXV) ? MAXV : p / CPU;
        e.hi   = (h / CPU > MAXV) ? MAXV : h / CPU;
        e.sat  = (e.per == MAXV) || (e.hi == MAXV);
        e.rcyc = 0;
        return e;
    endfunction

    // A rise closes the pending period (if armed and seen a previous rise).
    task automatic rise_now();
        if (pend_vld) begin
            pend.rcyc = cyc;
            q.push_back(pend);
            n_push++;
            last_per = pend.per;
            last_hi  = pend.hi;
        end
        sig_in = 1'b1;
    endtask

    task automatic period(input int h, input int p);
        rise_now();
        pend     = model(h, p);
        pend_vld = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic close_train();
        rise_now();
        pend_vld = 1'b0;
        repeat (20) @(negedge clk);
        meas_en = 1'b0;
        repeat (3) @(negedge clk);
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        meas_en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (valid) begin
            n_valid++;
            chk("valid_width", longint'(prev_v), 0);
            chk("valid_expected", longint'(q.size() > 0), 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("period_us", longint'(period_us), mon_e.per);
                chk("high_us", longint'(high_us), mon_e.hi);
                chk("sat", longint'(sat), longint'(mon_e.sat));
                chk("latency", cyc - mon_e.rcyc, LAT);
            end
        end
        prev_v = valid;
    end

    initial begin
        int p;
        int h;
        rst_n   = 1'b0;
        sig_in  = 1'b0;
        meas_en = 1'b0;
        #2;
        chk("rst_period", longint'(period_us), 0);
        chk("rst_high", longint'(high_us), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_valid", longint'(valid), 0);
        chk("rst_busy", longint'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        meas_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("busy_arm", longint'(busy), 0);

        // Nominal train: 100 us period, 25 us high.
        period(1000, 4000);
        chk("busy_low", longint'(busy), 1);
        period(1000, 4000);
        period(1000, 4000);
        close_train();

        // Rounding down at the microsecond boundaries.
        period(39, 3999);
        period(1000, 4040);
        close_train();

        // Counter saturation, then recovery.
        period(12000, 16000);
        period(1000, 4000);
        close_train();

        // Disable mid-high, re-enable while the input is still high.
        period(200, 800);
        period(200, 800);
        rise_now();
        pend_vld = 1'b0;
        repeat (100) @(negedge clk);
        meas_en = 1'b0;
        @(negedge clk);
        chk("busy_drop", longint'(busy), 0);
        repeat (20) @(negedge clk);
        chk("hold_period", longint'(period_us), last_per);
        chk("hold_high", longint'(high_us), last_hi);
        meas_en = 1'b1;
        repeat (50) @(negedge clk);
        sig_in = 1'b0;
        repeat (300) @(negedge clk);
        period(200, 800);
        period(300, 800);
        close_train();

        // Asynchronous reset in the low phase.
        rise_now();
        pend     = model(1000, 4000);
        pend_vld = 1'b1;
        repeat (1000) @(negedge clk);
        sig_in = 1'b0;
        repeat (1500) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        pend_vld = 1'b0;
        #1;
        chk("arst_period", longint'(period_us), 0);
        chk("arst_high", longint'(high_us), 0);
        chk("arst_sat", longint'(sat), 0);
        chk("arst_busy", longint'(busy), 0);
        repeat (3) @(negedge clk);
        chk("arst_hold_period", longint'(period_us), 0);
        rst_n = 1'b1;
        repeat (1500) @(negedge clk);
        period(1000, 4000);
        period(1000, 4000);
        close_train();

        // Random trains.
        repeat (6) begin
            p = int'($urandom_range(2500, 120));
            h = int'($urandom_range(p - 2, 2));
            period(h, p);
        end
        close_train();

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        chk("drain", longint'(q.size()), 0);
        chk("valid_count", n_valid, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
